// File: rtl/uart_echo_responder.sv
// uart_echo_responder: FIFO-buffered byte echo peer for the uart byte interface.
// Define UART_ECHO_UPCASE_EN to return 'a'..'z' as uppercase (converted on FIFO write).
module uart_echo_responder #(
  parameter int DEPTH_LOG2 = 3,
  parameter int GUARD = 4
) (
  input  logic                  clk32,
  input  logic                  reset_,
  input  logic [7:0]            rxdata,
  input  logic                  rx_enable,
  input  logic                  tx_ready,
  output logic [7:0]            txdata,
  output logic                  tx_enable,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                state_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [3:0]            guard_q;
  logic [7:0]            txdata_q, wdata;
  logic                  tx_enable_q, overflow_q, push, pop, full;

  assign full = count_q == (DEPTH_LOG2+1)'(DEPTH);
  assign pop  = state_q == IDLE && count_q != '0 && tx_ready;
  assign push = rx_enable && (!full || pop);
`ifdef UART_ECHO_UPCASE_EN
  assign wdata = (rxdata >= 8'h61 && rxdata <= 8'h7a) ? (rxdata & 8'hdf) : rxdata;
`else
  assign wdata = rxdata;
`endif

  assign txdata     = txdata_q;
  assign tx_enable  = tx_enable_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk32)
    if (push) mem_q[wr_ptr_q] <= wdata;

  // A push at full only lands because the same-edge pop reads the old head first.
  always_ff @(posedge clk32 or negedge reset_)
    if (!reset_) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      guard_q     <= '0;
      txdata_q    <= 8'h00;
      tx_enable_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      if (rx_enable && !push) overflow_q <= 1'b1;
      tx_enable_q <= pop;
      if (pop) txdata_q <= mem_q[rd_ptr_q];
      case (state_q)
        IDLE: if (pop) state_q <= SEND;
        SEND: begin
          state_q <= WAIT_BUSY;
          guard_q <= '0;
        end
        WAIT_BUSY:
          if (!tx_ready) state_q <= WAIT_DONE;
          else if (guard_q == 4'(GUARD - 1)) state_q <= IDLE;
          else guard_q <= guard_q + 1'b1;
        default: if (tx_ready) state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: directed checks of the echo responder against a busy-for-N-cycles UART model.
module tb_uart_echo_responder;
  logic       clk32 = 1'b0;
  logic       reset_ = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic       rx_enable = 1'b0;
  logic       host_ready = 1'b1;
  logic       tx_ready;
  logic [7:0] txdata;
  logic       tx_enable;
  logic [3:0] fifo_count;
  logic       overflow;
  int         model_busy = 0;
  int         busy_cnt = 0;
  int         dbl = 0;
  logic       prev_en = 1'b0;
  logic [7:0] outq [$];
  int         passed = 0;
  int         total = 0;
  int         base;

  uart_echo_responder dut (
    .clk32(clk32), .reset_(reset_), .rxdata(rxdata), .rx_enable(rx_enable),
    .tx_ready(tx_ready), .txdata(txdata), .tx_enable(tx_enable),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk32 = ~clk32;
  assign tx_ready = host_ready && busy_cnt == 0;

  // UART stand-in: accepts a pulse and stays busy for model_busy cycles.
  always @(negedge clk32) begin
    prev_en  <= tx_enable;
    busy_cnt <= tx_enable ? model_busy : (busy_cnt > 0 ? busy_cnt - 1 : 0);
    if (tx_enable && prev_en) dbl <= dbl + 1;
    if (tx_enable) outq.push_back(txdata);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk32);
    rxdata = b;
    rx_enable = 1'b1;
    @(negedge clk32);
    rx_enable = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 600 && outq.size() < n; i++) @(negedge clk32);
    chk("out_timeout", outq.size() >= n, 1);
  endtask

  task automatic do_reset();
    @(negedge clk32);
    reset_ = 1'b0;
    repeat (2) @(negedge clk32);
    reset_ = 1'b1;
  endtask

  initial begin
    logic [7:0] up [3];
    repeat (2) @(negedge clk32);
    chk("rst_txdata", txdata, 8'h00);
    chk("rst_txen", tx_enable, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    reset_ = 1'b1;
    repeat (2) @(negedge clk32);

    base = outq.size();
    @(negedge clk32);
    rxdata = 8'hA5;
    rx_enable = 1'b1;
    @(posedge clk32); #1;
    chk("single_cnt1", fifo_count, 1);
    chk("single_noen", tx_enable, 0);
    @(negedge clk32);
    rx_enable = 1'b0;
    @(posedge clk32); #1;
    chk("single_en", tx_enable, 1);
    chk("single_data", txdata, 8'hA5);
    chk("single_cnt0", fifo_count, 0);
    @(posedge clk32); #1;
    chk("single_enoff", tx_enable, 0);
    chk("single_hold", txdata, 8'hA5);
    repeat (12) @(negedge clk32);
    chk("single_pulses", outq.size() - base, 1);

    model_busy = 10;
    host_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    chk("burst_cnt8", fifo_count, 8);
    base = outq.size();
    host_ready = 1'b1;
    wait_out(base + 8);
    for (int i = 0; i < 8; i++) chk("burst_order", outq[base+i], 32'(i));
    chk("burst_ovf", overflow, 0);
    repeat (20) @(negedge clk32);

    host_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
    chk("ovf_cnt8", fifo_count, 8);
    chk("ovf_set", overflow, 1);
    base = outq.size();
    host_ready = 1'b1;
    wait_out(base + 8);
    repeat (40) @(negedge clk32);
    chk("ovf_total", outq.size() - base, 8);
    for (int i = 0; i < 8; i++) chk("ovf_order", outq[base+i], 8'h10 + 8'(i));
    chk("ovf_sticky", overflow, 1);

    do_reset();
    chk("rst2_ovf", overflow, 0);
    host_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'hE0 + 8'(i));
    base = outq.size();
    @(negedge clk32);
    rxdata = 8'hEE;
    rx_enable = 1'b1;
    host_ready = 1'b1;
    @(posedge clk32); #1;
    chk("full_pp_cnt", fifo_count, 8);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_en", tx_enable, 1);
    chk("full_pp_head", txdata, 8'hE0);
    @(negedge clk32);
    rx_enable = 1'b0;
    wait_out(base + 9);
    for (int i = 0; i < 8; i++) chk("full_pp_order", outq[base+i], 8'hE0 + 8'(i));
    chk("full_pp_last", outq[base+8], 8'hEE);
    chk("full_pp_ovf2", overflow, 0);
    repeat (20) @(negedge clk32);

    host_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
    base = outq.size();
    host_ready = 1'b1;
    wait_out(base + 1);
    repeat (3) @(negedge clk32);
    chk("mid_cnt3", fifo_count, 3);
    reset_ = 1'b0;
    #1;
    chk("mid_txdata", txdata, 8'h00);
    chk("mid_txen", tx_enable, 0);
    chk("mid_cnt", fifo_count, 0);
    chk("mid_ovf", overflow, 0);
    repeat (2) @(negedge clk32);
    reset_ = 1'b1;
    base = outq.size();
    repeat (30) @(negedge clk32);
    chk("mid_nopulse", outq.size() - base, 0);
    push_byte(8'h5A);
    wait_out(base + 1);
    chk("mid_new", outq[base], 8'h5A);
    repeat (20) @(negedge clk32);

`ifdef UART_ECHO_UPCASE_EN
    up = '{8'h41, 8'h41, 8'h7B};
`else
    up = '{8'h61, 8'h41, 8'h7B};
`endif
    base = outq.size();
    push_byte(8'h61);
    push_byte(8'h41);
    push_byte(8'h7B);
    wait_out(base + 3);
    for (int i = 0; i < 3; i++) chk("case_conv", outq[base+i], up[i]);
    repeat (20) @(negedge clk32);
    chk("no_back_to_back", dbl, 0);
    chk("final_cnt", fifo_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Byte-level echo responder on the far side of the `uart` byte interface: consumes received bytes (`rxdata`/`rx_enable`), buffers them in a small FIFO, and returns each one through the transmit side (`txdata`/`tx_enable`) when the UART reports `tx_ready`. It runs on the UART's 32 MHz clock domain and replaces the bench-side driver as the permanent loopback/bring-up peer, so a host on the serial line gets every byte echoed back in order.

## Interface
- `DEPTH_LOG2`, 3: FIFO depth = 2^DEPTH_LOG2 bytes; legal range 1..6.
- `GUARD`, 4: maximum cycles to wait for `tx_ready` to fall after a `tx_enable` pulse; legal range 1..15.

- `clk32`  in  1  system clock, 32 MHz, all state on rising edge.
- `reset_`  in  1  reset, asynchronous assert, active-low.
- `rxdata`  in  8  received byte; valid only in the cycle `rx_enable` is high.
- `rx_enable`  in  1  one-cycle pulse: new byte on `rxdata`.
- `tx_ready`  in  1  UART transmitter idle and able to accept a byte.
- `txdata`  out  8  byte to transmit; registered and held after the pulse.
- `tx_enable`  out  1  one-cycle pulse: transmit `txdata`.
- `fifo_count`  out  DEPTH_LOG2+1  bytes currently buffered.
- `overflow`  out  1  sticky: a byte arrived with the FIFO full and was dropped.

## Operation
- Reset (`reset_` low, any cycle): FIFO emptied, pointers 0, FSM to IDLE; `txdata`=8'h00, `tx_enable`=0, `fifo_count`=0, `overflow`=0. Reset mid-transmission aborts the FSM; no further pulse is issued.
- FIFO: circular, 2^DEPTH_LOG2 entries, DEPTH_LOG2-bit read/write pointers wrapping modulo depth; count is a separate DEPTH_LOG2+1-bit counter, 0..depth.
- Push: `rx_enable` high and (not full, or a pop in the same cycle) writes `rxdata`. With full and no pop: byte discarded, `overflow` set; it stays set until reset.
- Pop: occurs on the edge that issues `tx_enable`; head byte is loaded into `txdata` on the same edge.
- Simultaneous push and pop: both happen; count unchanged; legal at full and at count 1. Push into an empty FIFO is not visible to pop until the next cycle (no fall-through).
- FSM states:
  - IDLE: if count≠0 and `tx_ready`=1 -> pop, assert `tx_enable`, go to SEND.
  - SEND: `tx_enable` deasserted; go to WAIT_BUSY, guard counter = 0.
  - WAIT_BUSY: `tx_ready`=0 -> WAIT_DONE; else increment guard; guard reaching GUARD -> IDLE (UART accepted and finished faster than observable, or ignored pulse; no retry).
  - WAIT_DONE: `tx_ready`=1 -> IDLE.
- Exactly one `tx_enable` pulse per popped byte; output order equals arrival order.

## Timing
- `tx_enable` is never high for two consecutive cycles; minimum spacing between pulses is 3 cycles (SEND, WAIT_BUSY, then IDLE).
- Latency, FIFO empty and `tx_ready` high: `rx_enable` sampled at edge k -> `fifo_count`=1 after edge k -> `tx_enable` high and `txdata` valid after edge k+1, for one cycle; `fifo_count` back to 0 after edge k+1.
- `tx_ready` low in IDLE: byte stays buffered; pulse issued on the first edge after `tx_ready` returns high.
- `fifo_count` and `overflow` are registered and update on the edge following the causing event.

## Configuration
- `UART_ECHO_UPCASE_EN` defined: bytes 8'h61..8'h7A ('a'..'z') are returned with bit 5 cleared (uppercase); all other values unchanged. Conversion is applied on the FIFO write path; FIFO contents and `txdata` hold the converted value.
- Not defined: bytes echoed bit-exact; no conversion logic is present.

## Test plan
- Single byte: `tx_ready`=1, pulse `rx_enable` with 8'hA5 -> exactly one `tx_enable` two edges later with `txdata`=8'hA5; `fifo_count` 0->1->0.
- Burst/ordering: hold `tx_ready`=0, push 8'h00..8'h07 -> `fifo_count`=8; release `tx_ready` with UART model busying 10 cycles per byte -> 8 pulses, `txdata` 00..07 in order, `overflow`=0.
- Overflow: `tx_ready`=0, push 9 bytes 8'h10..8'h18 -> `fifo_count`=8, `overflow`=1; drain -> 10..17 echoed, 8'h18 never appears; `overflow` stays 1.
- Full with simultaneous push/pop: FIFO full, `tx_ready` rises in the same cycle as `rx_enable` with 8'hEE -> byte accepted, `fifo_count` stays 8, `overflow` stays 0, 8'hEE emitted last.
- Reset mid-operation: assert `reset_` low in WAIT_DONE with 3 bytes buffered -> all outputs 0 immediately, no `tx_enable` afterwards until a new `rx_enable`.
- Macro: with `UART_ECHO_UPCASE_EN`, push 8'h61, 8'h41, 8'h7B -> echoed 8'h41, 8'h41, 8'h7B; without it -> 8'h61, 8'h41, 8'h7B.
